// File: rtl/sfifo_cmp_ctrl.sv
// sfifo_cmp_ctrl: read/write pointer controller for a 2^ADDW-deep single-clock
// FIFO. Drives the RAM write strobe and both addresses. Keeps registered
// full/empty/threshold flags, a fill count, and sticky overflow/underflow flags.
module sfifo_cmp_ctrl #(
  parameter int unsigned ADDW      = 4,
  parameter int unsigned AFULL_TH  = 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic            flush,
  input  logic            err_clr,
  output logic            mem_we,
  output logic [ADDW-1:0] waddr,
  output logic [ADDW-1:0] raddr,
  output logic            full,
  output logic            empty,
  output logic            afull,
  output logic            aempty,
  output logic [ADDW:0]   count,
  output logic            ovf,
  output logic            udf
);

  localparam logic [ADDW:0] DEPTH_C    = {1'b1, {ADDW{1'b0}}};
  localparam logic [ADDW:0] AFULL_LVL  = DEPTH_C - (ADDW+1)'(AFULL_TH);
  localparam logic [ADDW:0] AEMPTY_LVL = (ADDW+1)'(AEMPTY_TH);
  // Threshold flag values for an empty FIFO (count = 0)
  localparam logic          AFULL_RST  = (AFULL_LVL == '0);
  localparam logic          AEMPTY_RST = 1'b1;

  logic [ADDW-1:0] wptr_q, wptr_d;
  logic [ADDW-1:0] rptr_q, rptr_d;
  logic            dir_q, dir_d;
  logic [ADDW:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            wr_acc, rd_acc;

  // Next-state logic for pointers, direction, count, flags and sticky errors
  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dir_d   = dir_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      dir_d   = 1'b0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      // dir records which side last caught up, so pointer equality
      // resolves to full (writer caught reader) or empty (reader caught writer)
      unique case ({wr_acc, rd_acc})
        2'b10: begin
          count_d = count_q + 1'b1;
          if (wptr_d == rptr_q) dir_d = 1'b1;
        end
        2'b01: begin
          count_d = count_q - 1'b1;
          if (rptr_d == wptr_q) dir_d = 1'b0;
        end
        default: ;
      endcase
    end
    full_d   = (wptr_d == rptr_d) & dir_d;
    empty_d  = (wptr_d == rptr_d) & ~dir_d;
    afull_d  = (count_d >= AFULL_LVL);
    aempty_d = (count_d <= AEMPTY_LVL);
    // Set wins over clear; a flush cycle never sets the error flags
    ovf_d    = (wr_en & full_q & ~flush) | (ovf_q & ~err_clr);
    udf_d    = (rd_en & empty_q & ~flush) | (udf_q & ~err_clr);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AFULL_RST;
      aempty_q <= AEMPTY_RST;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign mem_we = wr_en & ~full_q & ~flush & rst_n;
  assign waddr  = wptr_q;
  assign raddr  = rptr_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_sfifo_cmp_ctrl.sv
// Testbench for sfifo_cmp_ctrl: directed sequences plus randomized traffic,
// checked by a scoreboard fed from a behavioural FIFO-occupancy model.
module tb_sfifo_cmp_ctrl;

  localparam int ADDW      = 4;
  localparam int DEPTH     = 1 << ADDW;
  localparam int AFULL_TH  = 2;
  localparam int AEMPTY_TH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic            flush = 1'b0;
  logic            err_clr = 1'b0;
  logic            mem_we;
  logic [ADDW-1:0] waddr, raddr;
  logic            full, empty, afull, aempty, ovf, udf;
  logic [ADDW:0]   count;

  sfifo_cmp_ctrl #(
    .ADDW      (ADDW),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .flush   (flush),
    .err_clr (err_clr),
    .mem_we  (mem_we),
    .waddr   (waddr),
    .raddr   (raddr),
    .full    (full),
    .empty   (empty),
    .afull   (afull),
    .aempty  (aempty),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int wa;
    int ra;
    bit ovf;
    bit udf;
  } exp_t;

  exp_t exp_q[$];
  bit   we_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy and pointers as plain integers
  int  m_cnt = 0;
  int  m_w   = 0;
  int  m_r   = 0;
  bit  m_ovf = 1'b0;
  bit  m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; model predicts post-edge state and strobe
  task automatic step(input bit r, input bit w, input bit rd, input bit f, input bit ec);
    exp_t e;
    bit   is_full, is_empty, wa, ra;
    @(negedge clk);
    #1;
    rst_n = r; wr_en = w; rd_en = rd; flush = f; err_clr = ec;
    if (!r) begin
      m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      is_full  = (m_cnt == DEPTH);
      is_empty = (m_cnt == 0);
      we_q.push_back(w && !is_full && !f);
      m_ovf = (!f && w && is_full) || (m_ovf && !ec);
      m_udf = (!f && rd && is_empty) || (m_udf && !ec);
      if (f) begin
        m_cnt = 0; m_w = 0; m_r = 0;
      end else begin
        wa = w && !is_full;
        ra = rd && !is_empty;
        if (wa) begin m_w = (m_w + 1) % DEPTH; m_cnt++; end
        if (ra) begin m_r = (m_r + 1) % DEPTH; m_cnt--; end
      end
    end
    e.cnt = m_cnt; e.wa = m_w; e.ra = m_r; e.ovf = m_ovf; e.udf = m_udf;
    exp_q.push_back(e);
  endtask

  // Registered-output monitor: compares after every active edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",  count,  e.cnt);
        chk("full",   full,   e.cnt == DEPTH);
        chk("empty",  empty,  e.cnt == 0);
        chk("afull",  afull,  (DEPTH - e.cnt) <= AFULL_TH);
        chk("aempty", aempty, e.cnt <= AEMPTY_TH);
        chk("ovf",    ovf,    e.ovf);
        chk("udf",    udf,    e.udf);
        chk("waddr",  waddr,  e.wa);
        chk("raddr",  raddr,  e.ra);
        chk("ptr_eq_vs_flags", (waddr == raddr), (full || empty));
        chk("full_vs_count",   full,  (count == DEPTH));
        chk("empty_vs_count",  empty, (count == 0));
      end
    end
  end

  // Write-strobe monitor: mem_we is combinational, sampled mid low phase
  initial begin
    bit we;
    forever begin
      @(negedge clk);
      #2;
      if (we_q.size() > 0) begin
        we = we_q.pop_front();
        chk("mem_we", mem_we, we);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int wp, rp;
    // Reset, then fill to full
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0);
    // Overflow attempt, then clear
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    // From full: simultaneous read/write twice
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    // Drain to empty via flush, then simultaneous op on empty and reads past empty
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0);
    // Count 9 with rptr != 0, flush with a write pending
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    // Overflow flag still set, fill to 7 and reset mid-fill
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    // err_clr and set in the same cycle: set wins
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    // Randomized traffic with phase-varying read/write bias
    wp = 50; rp = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 250 == 0) begin
        wp = $urandom_range(90, 10);
        rp = $urandom_range(90, 10);
      end
      step(($urandom_range(999) != 0),
           ($urandom_range(99) < wp),
           ($urandom_range(99) < rp),
           ($urandom_range(63) == 0),
           ($urandom_range(31) == 0));
    end
    step(1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    @(negedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size() + we_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
